// File: rtl/branch_resolver.sv
// Branch resolver: execute-side partner of the fetch branch predictor.
// Holds an in-order queue of fetch predictions, compares the oldest one against
// the resolved outcome, emits the predictor update, and on a mispredict issues a
// fetch redirect plus a fixed-length pipeline flush. Also keeps saturating
// branch / mispredict statistics.
module branch_resolver #(
    parameter int unsigned WIDTH_PC     = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    // Prediction push from fetch
    input  logic                i_pred_valid,
    input  logic [WIDTH_PC-1:0] i_pred_pc,
    input  logic                i_pred_jump,
    input  logic [WIDTH_PC-1:0] i_pred_target,
    output logic                o_pred_ready,
    // Resolution from execute
    input  logic                i_ex_valid,
    input  logic                i_ex_taken,
    input  logic [WIDTH_PC-1:0] i_ex_target,
    // Predictor update
    output logic                o_upd_valid,
    output logic                o_upd_wrong,
    output logic [WIDTH_PC-1:0] o_upd_pc,
    output logic [WIDTH_PC-1:0] o_upd_target,
    // Fetch redirect and flush
    output logic                o_redirect_valid,
    output logic [WIDTH_PC-1:0] o_redirect_pc,
    output logic                o_flush,
    // Status and statistics
    output logic                o_underflow_err,
    output logic [CNT_WIDTH-1:0] o_branch_cnt,
    output logic [CNT_WIDTH-1:0] o_mispredict_cnt
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned QCNT_W = $clog2(DEPTH + 1);
    localparam int unsigned FL_W   = $clog2(FLUSH_CYCLES + 1);

    localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1);
    localparam logic [QCNT_W-1:0]   QCNT_ONE   = QCNT_W'(1);
    localparam logic [QCNT_W-1:0]   QCNT_DEPTH = QCNT_W'(DEPTH);
    localparam logic [FL_W-1:0]     FL_ONE     = FL_W'(1);
    localparam logic [FL_W-1:0]     FL_LOAD    = FL_W'(FLUSH_CYCLES);
    localparam logic [WIDTH_PC-1:0] PC_STEP    = WIDTH_PC'(4);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [0:0] {
        StIdle,
        StFlush
    } state_e;

    // Control state
    state_e              r_state;
    logic [FL_W-1:0]     r_flush_cnt;
    logic                r_flush;

    // Prediction queue (circular buffer)
    logic [WIDTH_PC-1:0] r_q_pc     [DEPTH];
    logic                r_q_jump   [DEPTH];
    logic [WIDTH_PC-1:0] r_q_target [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [QCNT_W-1:0]   r_count;

    // Registered resolution outputs
    logic                r_upd_valid;
    logic                r_upd_wrong;
    logic [WIDTH_PC-1:0] r_upd_pc;
    logic [WIDTH_PC-1:0] r_upd_target;
    logic                r_redirect_valid;
    logic [WIDTH_PC-1:0] r_redirect_pc;
    logic                r_underflow;
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_mispredict_cnt;

    // Combinational decode
    logic                w_idle;
    logic                w_ready;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_underflow;
    logic                w_mispredict;
    logic [WIDTH_PC-1:0] w_head_pc;
    logic                w_head_jump;
    logic [WIDTH_PC-1:0] w_head_target;
    logic [WIDTH_PC-1:0] w_next_pc;
    logic                w_wrong;

    // Queue handshake: ready depends only on registered state, never on ex_valid
    always_comb begin
        w_idle      = (r_state == StIdle);
        w_empty     = (r_count == '0);
        w_ready     = w_idle && (r_count < QCNT_DEPTH);
        w_push      = i_pred_valid && w_ready;
        w_pop       = i_ex_valid && w_idle && !w_empty;
        w_underflow = i_ex_valid && w_idle && w_empty;
    end

    // Compare the head prediction with the actual outcome
    always_comb begin
        w_head_pc     = r_q_pc[r_rd_ptr];
        w_head_jump   = r_q_jump[r_rd_ptr];
        w_head_target = r_q_target[r_rd_ptr];
        w_next_pc     = i_ex_taken ? i_ex_target : (w_head_pc + PC_STEP);
        // A not-taken/not-taken match is correct whatever the targets hold
        w_wrong       = (w_head_jump != i_ex_taken) ||
                        (i_ex_taken && (w_head_target != i_ex_target));
        w_mispredict  = w_pop && w_wrong;
    end

    // Queue storage; a push coinciding with a mispredict is discarded
    always_ff @(posedge i_clk) begin
        if (w_push && !w_mispredict) begin
            r_q_pc[r_wr_ptr]     <= i_pred_pc;
            r_q_jump[r_wr_ptr]   <= i_pred_jump;
            r_q_target[r_wr_ptr] <= i_pred_target;
        end
    end

    // Queue pointers and occupancy; mispredict empties the queue
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_mispredict) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // Simultaneous push and pop leaves occupancy unchanged
            if (w_push && !w_pop) begin
                r_count <= r_count + QCNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - QCNT_ONE;
            end
        end
    end

    // Control FSM: timed flush after a mispredict, flush output registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_flush_cnt <= '0;
            r_flush     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_mispredict) begin
                        r_state     <= StFlush;
                        r_flush_cnt <= FL_LOAD;
                        r_flush     <= 1'b1;
                    end
                end
                StFlush: begin
                    // Leaving on count 1 keeps flush high for exactly FLUSH_CYCLES cycles
                    if (r_flush_cnt == FL_ONE) begin
                        r_state     <= StIdle;
                        r_flush_cnt <= '0;
                        r_flush     <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FL_ONE;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_flush_cnt <= '0;
                    r_flush     <= 1'b0;
                end
            endcase
        end
    end

    // Resolution outputs: one-cycle strobes, payload held between resolutions
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_upd_valid      <= 1'b0;
            r_upd_wrong      <= 1'b0;
            r_upd_pc         <= '0;
            r_upd_target     <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_upd_valid      <= w_pop;
            r_redirect_valid <= w_mispredict;
            if (w_pop) begin
                r_upd_wrong  <= w_wrong;
                r_upd_pc     <= w_head_pc;
                r_upd_target <= w_next_pc;
            end
            if (w_mispredict) begin
                r_redirect_pc <= w_next_pc;
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_pop && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            end
            if (w_mispredict && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
            end
        end
    end

    // Sticky error: execute resolved a branch that fetch never queued
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_underflow <= 1'b0;
        end else if (w_underflow) begin
            r_underflow <= 1'b1;
        end
    end

    assign o_pred_ready     = w_ready;
    assign o_upd_valid      = r_upd_valid;
    assign o_upd_wrong      = r_upd_wrong;
    assign o_upd_pc         = r_upd_pc;
    assign o_upd_target     = r_upd_target;
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_flush          = r_flush;
    assign o_underflow_err  = r_underflow;
    assign o_branch_cnt     = r_branch_cnt;
    assign o_mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_branch_resolver;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int FC = 2;
    localparam int CW = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pred_valid;
    logic [W-1:0]  pred_pc;
    logic          pred_jump;
    logic [W-1:0]  pred_target;
    logic          pred_ready;
    logic          ex_valid;
    logic          ex_taken;
    logic [W-1:0]  ex_target;
    logic          upd_valid;
    logic          upd_wrong;
    logic [W-1:0]  upd_pc;
    logic [W-1:0]  upd_target;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          flush;
    logic          underflow_err;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispredict_cnt;

    always #5 clk = ~clk;

    branch_resolver #(
        .WIDTH_PC     (W),
        .DEPTH        (D),
        .FLUSH_CYCLES (FC),
        .CNT_WIDTH    (CW)
    ) u_dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_pred_valid     (pred_valid),
        .i_pred_pc        (pred_pc),
        .i_pred_jump      (pred_jump),
        .i_pred_target    (pred_target),
        .o_pred_ready     (pred_ready),
        .i_ex_valid       (ex_valid),
        .i_ex_taken       (ex_taken),
        .i_ex_target      (ex_target),
        .o_upd_valid      (upd_valid),
        .o_upd_wrong      (upd_wrong),
        .o_upd_pc         (upd_pc),
        .o_upd_target     (upd_target),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc),
        .o_flush          (flush),
        .o_underflow_err  (underflow_err),
        .o_branch_cnt     (branch_cnt),
        .o_mispredict_cnt (mispredict_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        jump;
        logic [31:0] tgt;
    } pred_t;

    pred_t       mq[$];
    int          m_flush_left;
    logic        m_uv, m_uw, m_rv, m_fl, m_uf;
    logic [31:0] m_upc, m_ut, m_rpc;
    int          m_bc, m_mc;

    task automatic model_step();
        pred_t       h;
        pred_t       p;
        logic [31:0] nxt;
        logic        wr;
        logic        do_push;
        m_uv = 1'b0;
        m_rv = 1'b0;
        if (rst) begin
            mq.delete();
            m_flush_left = 0;
            m_fl = 1'b0;
            m_uf = 1'b0;
            m_bc = 0;
            m_mc = 0;
            return;
        end
        if (m_flush_left > 0) begin
            m_flush_left--;
            m_fl = (m_flush_left > 0);
            return;
        end
        do_push = pred_valid && (mq.size() < D);
        if (ex_valid && mq.size() > 0) begin
            h   = mq.pop_front();
            nxt = ex_taken ? ex_target : h.pc + 32'd4;
            wr  = (h.jump != ex_taken) || (ex_taken && h.tgt != ex_target);
            m_uv = 1'b1;
            m_uw = wr;
            m_upc = h.pc;
            m_ut = nxt;
            if (m_bc < CNT_MAX) m_bc++;
            if (wr) begin
                m_rv = 1'b1;
                m_rpc = nxt;
                if (m_mc < CNT_MAX) m_mc++;
                mq.delete();
                m_flush_left = FC;
                m_fl = 1'b1;
                return;
            end
        end else if (ex_valid) begin
            m_uf = 1'b1;
        end
        if (do_push) begin
            p.pc = pred_pc;
            p.jump = pred_jump;
            p.tgt = pred_target;
            mq.push_back(p);
        end
    endtask

    task automatic check_all();
        chk("pred_ready", pred_ready, (m_flush_left == 0 && mq.size() < D));
        chk("upd_valid", upd_valid, m_uv);
        chk("redirect_valid", redirect_valid, m_rv);
        chk("flush", flush, m_fl);
        chk("underflow_err", underflow_err, m_uf);
        chk("branch_cnt", branch_cnt, m_bc);
        chk("mispredict_cnt", mispredict_cnt, m_mc);
        if (m_uv) begin
            chk("upd_wrong", upd_wrong, m_uw);
            chk("upd_pc", upd_pc, m_upc);
            chk("upd_target", upd_target, m_ut);
        end
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    // Inputs are changed on the falling edge; outputs compared on the next one
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input logic pv, input logic [31:0] ppc, input logic pj,
                          input logic [31:0] pt, input logic ev, input logic et,
                          input logic [31:0] etgt);
        pred_valid = pv;
        pred_pc = ppc;
        pred_jump = pj;
        pred_target = pt;
        ex_valid = ev;
        ex_taken = et;
        ex_target = etgt;
    endtask

    task automatic idle_in();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        pj;
        logic [31:0] pt;
        logic        ev;
        logic        et;
        logic [31:0] etgt;
        logic        e_ready;
        logic        e_uv;
        logic        e_uw;
        logic [31:0] e_ut;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_fl;
        logic        e_uf;
        int          e_bc;
        int          e_mc;
    } vec_t;

    function automatic vec_t mk(
        logic pv, logic [31:0] ppc, logic pj, logic [31:0] pt,
        logic ev, logic et, logic [31:0] etgt,
        logic e_ready, logic e_uv, logic e_uw, logic [31:0] e_ut,
        logic e_rv, logic [31:0] e_rpc, logic e_fl, logic e_uf, int e_bc, int e_mc);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.pj = pj; v.pt = pt;
        v.ev = ev; v.et = et; v.etgt = etgt;
        v.e_ready = e_ready; v.e_uv = e_uv; v.e_uw = e_uw; v.e_ut = e_ut;
        v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_fl = e_fl; v.e_uf = e_uf;
        v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    vec_t tbl[11];

    function automatic logic [31:0] pc_of(int k);
        return 32'h1000 + 32'(4 * k);
    endfunction

    function automatic logic [31:0] tgt_of(int k);
        return 32'h2000 + 32'(16 * k);
    endfunction

    initial begin
        int popk;
        int pushk;
        logic [31:0] rt;
        logic        rtk;

        //            pv  ppc        pj  pt         ev  et  etgt     | rdy uv uw ut         rv rpc        fl uf bc mc
        tbl[0]  = mk(1, 32'h100, 1, 32'h200, 0, 0, 32'h0,     1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
        tbl[1]  = mk(0, 32'h0,   0, 32'h0,   1, 1, 32'h200,   1, 1, 0, 32'h200, 0, 32'h0,   0, 0, 1, 0);
        tbl[2]  = mk(1, 32'h104, 0, 32'h0,   0, 0, 32'h0,     1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0);
        tbl[3]  = mk(0, 32'h0,   0, 32'h0,   1, 1, 32'h300,   0, 1, 1, 32'h300, 1, 32'h300, 1, 0, 2, 1);
        tbl[4]  = mk(1, 32'h999, 1, 32'h0,   1, 1, 32'h300,   0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 2, 1);
        tbl[5]  = mk(0, 32'h0,   0, 32'h0,   1, 1, 32'h300,   1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 2, 1);
        tbl[6]  = mk(1, 32'h108, 1, 32'h400, 0, 0, 32'h0,     1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 2, 1);
        tbl[7]  = mk(0, 32'h0,   0, 32'h0,   1, 0, 32'h0,     0, 1, 1, 32'h10C, 1, 32'h10C, 1, 0, 3, 2);
        tbl[8]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,     0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 3, 2);
        tbl[9]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,     1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 3, 2);
        tbl[10] = mk(0, 32'h0,   0, 32'h0,   1, 0, 32'h0,     1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 3, 2);

        m_flush_left = 0;
        m_uv = 0; m_uw = 0; m_rv = 0; m_fl = 0; m_uf = 0;
        m_upc = 0; m_ut = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
        rst = 1'b1;
        idle_in();
        @(negedge clk);

        // Reset state
        do_reset();
        chk("rst_pred_ready", pred_ready, 1'b1);
        chk("rst_branch_cnt", branch_cnt, 32'h0);

        // Directed table: correct taken, mispredict not-taken->taken, taken->not-taken
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].pv, tbl[i].ppc, tbl[i].pj, tbl[i].pt,
                   tbl[i].ev, tbl[i].et, tbl[i].etgt);
            tick();
            chk($sformatf("vec%0d_ready", i), pred_ready, tbl[i].e_ready);
            chk($sformatf("vec%0d_upd_valid", i), upd_valid, tbl[i].e_uv);
            chk($sformatf("vec%0d_redirect_valid", i), redirect_valid, tbl[i].e_rv);
            chk($sformatf("vec%0d_flush", i), flush, tbl[i].e_fl);
            chk($sformatf("vec%0d_underflow", i), underflow_err, tbl[i].e_uf);
            chk($sformatf("vec%0d_branch_cnt", i), branch_cnt, tbl[i].e_bc);
            chk($sformatf("vec%0d_mispredict_cnt", i), mispredict_cnt, tbl[i].e_mc);
            if (tbl[i].e_uv) begin
                chk($sformatf("vec%0d_upd_wrong", i), upd_wrong, tbl[i].e_uw);
                chk($sformatf("vec%0d_upd_target", i), upd_target, tbl[i].e_ut);
            end
            if (tbl[i].e_rv) chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, tbl[i].e_rpc);
        end

        // Full queue, dropped push, FIFO order across pointer wrap
        do_reset();
        popk = 0;
        for (pushk = 0; pushk < 4; pushk++) begin
            set_in(1, pc_of(pushk), 1, tgt_of(pushk), 0, 0, 0);
            tick();
        end
        chk("full_ready_low", pred_ready, 1'b0);
        set_in(1, 32'hDEAD_0000, 1, 32'hDEAD_0100, 0, 0, 0);
        tick();
        chk("full_ready_still_low", pred_ready, 1'b0);
        set_in(0, 0, 0, 0, 1, 1, tgt_of(popk));
        tick();
        chk("fifo_order", upd_pc, pc_of(popk));
        popk++;
        // Pop and push together: occupancy holds at 3, back-to-back updates
        for (int i = 0; i < 3; i++) begin
            set_in(1, pc_of(pushk), 1, tgt_of(pushk), 1, 1, tgt_of(popk));
            tick();
            chk("fifo_order", upd_pc, pc_of(popk));
            chk("b2b_upd_valid", upd_valid, 1'b1);
            popk++;
            pushk++;
        end
        chk("pop_push_ready", pred_ready, 1'b1);
        set_in(1, pc_of(pushk), 1, tgt_of(pushk), 0, 0, 0);
        tick();
        pushk++;
        chk("refill_ready_low", pred_ready, 1'b0);
        while (popk < 8) begin
            set_in(0, 0, 0, 0, 1, 1, tgt_of(popk));
            tick();
            chk("fifo_order", upd_pc, pc_of(popk));
            popk++;
        end

        // Mispredict with three queued and a push in the same cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h3000 + 32'(4 * i), 0, 32'h0, 0, 0, 0);
            tick();
        end
        set_in(1, 32'h3100, 0, 32'h0, 1, 1, 32'h5000);
        tick();
        chk("mp3_redirect_pc", redirect_pc, 32'h5000);
        idle_in();
        for (int i = 0; i < FC; i++) tick();
        set_in(0, 0, 0, 0, 1, 0, 0);
        tick();
        chk("mp3_underflow", underflow_err, 1'b1);
        chk("mp3_no_update", upd_valid, 1'b0);

        // PC+4 wraps modulo 2^32; then reset lands mid-flush
        set_in(1, 32'hFFFF_FFFC, 1, 32'h10, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 32'h10);
        tick();
        chk("wrap_redirect_pc", redirect_pc, 32'h0);
        chk("wrap_flush", flush, 1'b1);
        do_reset();
        chk("rstflush_flush", flush, 1'b0);
        chk("rstflush_ready", pred_ready, 1'b1);
        chk("rstflush_bc", branch_cnt, 32'h0);
        chk("rstflush_mc", mispredict_cnt, 32'h0);
        chk("rstflush_uf", underflow_err, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            rt  = 32'h8000 + 32'(16 * $urandom_range(0, 3));
            rtk = $urandom_range(0, 1);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                rtk = mq[0].jump;
                if (rtk) rt = mq[0].tgt;
            end
            set_in($urandom_range(0, 1),
                   ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                   $urandom_range(0, 1),
                   32'h8000 + 32'(16 * $urandom_range(0, 3)),
                   ($urandom_range(0, 99) < 45), rtk, rt);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
